// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample/frame widths, frame field layout and
// the I2S capture FSM state type.
package audio_pkg;

    localparam int AUDIO_SAMPLE_BITS = 16;
    localparam int AUDIO_FRAME_BITS  = 2 * AUDIO_SAMPLE_BITS;

    // Frame layout {Left, Right}, identical to what the playback path sends.
    localparam int AUDIO_LEFT_LSB    = AUDIO_FRAME_BITS - AUDIO_SAMPLE_BITS;
    localparam int AUDIO_RIGHT_LSB   = 0;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        RX_LEFT  = 2'd1,
        RX_RIGHT = 2'd2
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy; reused by the
// playback path. DEPTH must be a power of two.
module i2s_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign level    = cnt_q;
    assign pop_data = empty ? '0 : mem_q[rd_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
        end
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// Slave I2S capture deserializer: oversamples SCK/WS/SD, rebuilds {L,R} frames
// and queues them in a FWFT FIFO. Define I2S_RX_PEAK_EN for per-channel peak meters.
module i2s_receiver
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic                        Enable,
    input  logic                        ADC_I2S_CLK,
    input  logic                        ADC_I2S_WS,
    input  logic                        ADC_I2S_DATA,
    output logic [2*SAMPLE_BITS-1:0]    SampleData,
    output logic                        SampleValid,
    input  logic                        SampleReady,
    output logic [$clog2(FIFO_DEPTH):0] Level,
    output logic                        Overflow,
    output logic                        SyncError,
    input  logic                        ErrorClear
`ifdef I2S_RX_PEAK_EN
    ,
    input  logic                        PeakClear,
    output logic [SAMPLE_BITS-2:0]      PeakLeft,
    output logic [SAMPLE_BITS-2:0]      PeakRight
`endif
);
    localparam int CW = $clog2(SAMPLE_BITS + 1);

    // Input conditioning: 2-FF synchronizers, then a registered edge stage.
    logic [1:0] sck_sync_q, sck_sync_d;
    logic [1:0] ws_sync_q, ws_sync_d;
    logic [1:0] sd_sync_q, sd_sync_d;
    logic       sck_prev_q, sck_prev_d;
    logic       rise_q, rise_d;
    logic       ws_smp_q, ws_smp_d;
    logic       sd_smp_q, sd_smp_d;

    always_comb begin
        sck_sync_d = {sck_sync_q[0], ADC_I2S_CLK};
        ws_sync_d  = {ws_sync_q[0], ADC_I2S_WS};
        sd_sync_d  = {sd_sync_q[0], ADC_I2S_DATA};
        sck_prev_d = sck_sync_q[1];
        rise_d     = sck_sync_q[1] & ~sck_prev_q;
        ws_smp_d   = ws_sync_q[1];
        sd_smp_d   = sd_sync_q[1];
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            sck_sync_q <= '0;
            ws_sync_q  <= '0;
            sd_sync_q  <= '0;
            sck_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            ws_smp_q   <= 1'b0;
            sd_smp_q   <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            ws_sync_q  <= ws_sync_d;
            sd_sync_q  <= sd_sync_d;
            sck_prev_q <= sck_prev_d;
            rise_q     <= rise_d;
            ws_smp_q   <= ws_smp_d;
            sd_smp_q   <= sd_smp_d;
        end
    end

    // Word assembly and frame FSM
    i2s_rx_state_t            state_q;
    logic [CW-1:0]            bitcnt_q;
    logic [SAMPLE_BITS-1:0]   shift_q, left_q, shift_nx;
    logic [2*SAMPLE_BITS-1:0] frame_q;
    logic                     ws_last_q, push_q, short_q;
    logic                     have_room, ws_edge, word_short;

    // The bit at a WS change is the LSB of the ending word, so it is counted
    // before the short-word test.
    always_comb begin
        have_room  = (bitcnt_q < CW'(SAMPLE_BITS));
        shift_nx   = have_room ? {shift_q[SAMPLE_BITS-2:0], sd_smp_q} : shift_q;
        ws_edge    = (ws_smp_q != ws_last_q);
        word_short = (bitcnt_q < CW'(SAMPLE_BITS - 1));
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q   <= HUNT;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            left_q    <= '0;
            frame_q   <= '0;
            ws_last_q <= 1'b0;
            push_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            push_q  <= 1'b0;
            short_q <= 1'b0;
            if (rise_q) begin
                ws_last_q <= ws_smp_q;
            end
            if (!Enable) begin
                state_q  <= HUNT;
                bitcnt_q <= '0;
            end else if (rise_q) begin
                shift_q <= shift_nx;
                if (!ws_edge) begin
                    if (have_room) begin
                        bitcnt_q <= bitcnt_q + CW'(1);
                    end
                end else begin
                    bitcnt_q <= '0;
                    case (state_q)
                        HUNT: begin
                            if (!ws_smp_q) begin
                                state_q <= RX_LEFT;
                            end
                        end
                        RX_LEFT: begin
                            if (word_short) begin
                                state_q <= HUNT;
                                short_q <= 1'b1;
                            end else begin
                                left_q  <= shift_nx;
                                state_q <= RX_RIGHT;
                            end
                        end
                        RX_RIGHT: begin
                            if (word_short) begin
                                state_q <= HUNT;
                                short_q <= 1'b1;
                            end else begin
                                frame_q <= {left_q, shift_nx};
                                push_q  <= 1'b1;
                                state_q <= RX_LEFT;
                            end
                        end
                        default: state_q <= HUNT;
                    endcase
                end
            end
        end
    end

    // Frame buffer
    logic pop, fifo_full, fifo_empty;

    assign SampleValid = ~fifo_empty;
    assign pop         = SampleValid & SampleReady;

    i2s_rx_fifo #(
        .WIDTH (2 * SAMPLE_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (Reset),
        .push      (push_q),
        .push_data (frame_q),
        .pop       (pop),
        .pop_data  (SampleData),
        .level     (Level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky error flags; a new set beats a simultaneous clear.
    logic ovf_q, ovf_d, serr_q, serr_d;

    always_comb begin
        ovf_d  = (ovf_q & ~ErrorClear) | (push_q & fifo_full & ~pop);
        serr_d = (serr_q & ~ErrorClear) | short_q;
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            ovf_q  <= 1'b0;
            serr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            serr_q <= serr_d;
        end
    end

    assign Overflow  = ovf_q;
    assign SyncError = serr_q;

`ifdef I2S_RX_PEAK_EN
    // |x| of a two's-complement sample, with the most negative value clipped.
    function automatic logic [SAMPLE_BITS-2:0] magnitude(input logic [SAMPLE_BITS-1:0] s);
        logic [SAMPLE_BITS-1:0] n;
        n = '0 - s;
        if (!s[SAMPLE_BITS-1]) return s[SAMPLE_BITS-2:0];
        if (n[SAMPLE_BITS-1]) return '1;
        return n[SAMPLE_BITS-2:0];
    endfunction

    logic [SAMPLE_BITS-2:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d, mag_l, mag_r;

    always_comb begin
        mag_l    = magnitude(frame_q[2*SAMPLE_BITS-1:SAMPLE_BITS]);
        mag_r    = magnitude(frame_q[SAMPLE_BITS-1:0]);
        peak_l_d = PeakClear ? '0 : peak_l_q;
        peak_r_d = PeakClear ? '0 : peak_r_q;
        if (push_q & (~fifo_full | pop)) begin
            if (mag_l > peak_l_d) peak_l_d = mag_l;
            if (mag_r > peak_r_d) peak_r_d = mag_r;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign PeakLeft  = peak_l_q;
    assign PeakRight = peak_r_q;
`endif

endmodule
